// File: rtl/game_progress.sv
// ---------------------------------------------------------------------------
// game_progress
//
// Purpose:
//   Tracks per-level kill progress, player hit points and the cumulative
//   score for the game state controller. Collision and hit pulses from the
//   sprite logic come in. The level-complete code (cont) and the alive flag
//   (health) go out to the game FSM. All outputs are registered.
//
// Configuration macro:
//   GODMODE_EN  - when defined, player_hit is ignored completely. hp stays at
//                 MAX_HEALTH, health stays 1, and DEAD can never be reached.
//
// Ports:
//   Clk         in   1   system clock
//   Reset_n     in   1   synchronous reset, active low
//   frame_tick  in   1   one-cycle pulse per video frame
//   level       in   3   FSM level code: 0=Start 1..3=playing 4=End 5=Gameover
//   enemy_kill  in   1   one-cycle pulse, one enemy destroyed
//   player_hit  in   1   one-cycle pulse, player struck
//   cont        out  3   level-complete code: 001 L1, 010 L2, 100 L3, else 000
//   health      out  1   1 = player alive, 0 = dead
//   hp          out  3   remaining hit points
//   kill_count  out  5   kills in the current level
//   score       out  16  cumulative score (saturating)
// ---------------------------------------------------------------------------
module game_progress #(
    parameter int KILLS_L1     = 8,
    parameter int KILLS_L2     = 12,
    parameter int KILLS_L3     = 16,
    parameter int MAX_HEALTH   = 3,
    parameter int HIT_COOLDOWN = 60
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [2:0]  level,
    input  logic        enemy_kill,
    input  logic        player_hit,
    output logic [2:0]  cont,
    output logic        health,
    output logic [2:0]  hp,
    output logic [4:0]  kill_count,
    output logic [15:0] score
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        CLEARED,
        DEAD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  lvl_q;
    logic [7:0]  cooldown;

    logic [2:0]  cont_next;
    logic        health_next;
    logic [2:0]  hp_next;
    logic [4:0]  kill_next;
    logic [15:0] score_next;
    logic [7:0]  cooldown_next;

    logic [4:0]  target;
    logic        level_change;
    logic        level_playable;
    logic        kill_accept;
    logic        hit_accept;
    logic [16:0] score_sum;

    // Kill target for the level currently shown by the FSM.
    always_comb begin
        target = 5'd0;
        case (level)
            3'd1:    target = 5'(KILLS_L1);
            3'd2:    target = 5'(KILLS_L2);
            3'd3:    target = 5'(KILLS_L3);
            default: target = 5'd0;
        endcase
    end

    assign level_change   = (level != lvl_q);
    assign level_playable = (level >= 3'd1) && (level <= 3'd3);

    // A kill landing in the same cycle as a level change is dropped. It would
    // otherwise be credited to a level whose counter is being cleared.
    assign kill_accept = enemy_kill && (state == PLAY) && !level_change && level_playable;

    // One extra bit catches the overflow so the score can saturate.
    assign score_sum = {1'b0, score} + (17'(level) * 17'd10);

`ifdef GODMODE_EN
    assign hit_accept = 1'b0;
`else
    assign hit_accept = player_hit && ((state == PLAY) || (state == CLEARED)) &&
                        (cooldown == 8'd0) && (hp != 3'd0);
`endif

    // The datapath updates come first: kills, level-change clear, hits and
    // cooldown. The state decision is made after them. It can then look at
    // the post-hit hp, which lets a fatal hit override a level clear that
    // happens in the same cycle.
    always_comb begin
        state_next    = state;
        cont_next     = cont;
        hp_next       = hp;
        kill_next     = kill_count;
        score_next    = score;
        cooldown_next = cooldown;
        health_next   = health;

        if (kill_accept) begin
            kill_next  = (kill_count >= target) ? target : kill_count + 5'd1;
            score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end

        if (level_change) begin
            kill_next = 5'd0;
            cont_next = 3'b000;
        end

        if (hit_accept) begin
            hp_next       = hp - 3'd1;
            cooldown_next = 8'(HIT_COOLDOWN);
        end else if (frame_tick && (cooldown != 8'd0)) begin
            cooldown_next = cooldown - 8'd1;
        end

        case (state)
            IDLE: begin
                if (level_playable) begin
                    state_next = PLAY;
                end else if (level == 3'd0) begin
                    hp_next    = 3'(MAX_HEALTH);
                    score_next = 16'd0;
                    kill_next  = 5'd0;
                end
            end
            PLAY: begin
                if (hp_next == 3'd0) begin
                    state_next = DEAD;
                    cont_next  = 3'b000;
                end else if (!level_playable) begin
                    // End/Gameover codes drop back without clearing.
                    // The score therefore stays visible.
                    state_next = IDLE;
                end else if (kill_accept && (kill_next == target)) begin
                    state_next = CLEARED;
                    cont_next  = 3'b001 << (level - 3'd1);
                end
            end
            CLEARED: begin
                if (hp_next == 3'd0) begin
                    state_next = DEAD;
                    cont_next  = 3'b000;
                end else if (level_change) begin
                    state_next = level_playable ? PLAY : IDLE;
                end
            end
            DEAD: begin
                // Checking for level 0 rather than for a change into level 0
                // avoids a lock-up. Otherwise a death in the same cycle as a
                // move to level 0 would leave the block stuck in DEAD.
                if (level == 3'd0) begin
                    state_next = IDLE;
                    hp_next    = 3'(MAX_HEALTH);
                    score_next = 16'd0;
                    kill_next  = 5'd0;
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef GODMODE_EN
        health_next = 1'b1;
`else
        health_next = (hp_next != 3'd0);
`endif
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            lvl_q      <= 3'd0;
            cont       <= 3'b000;
            health     <= 1'b1;
            hp         <= 3'(MAX_HEALTH);
            kill_count <= 5'd0;
            score      <= 16'd0;
            cooldown   <= 8'd0;
        end else begin
            state      <= state_next;
            lvl_q      <= level;
            cont       <= cont_next;
            health     <= health_next;
            hp         <= hp_next;
            kill_count <= kill_next;
            score      <= score_next;
            cooldown   <= cooldown_next;
        end
    end

endmodule

// File: tb/tb_game_progress.sv
// ---------------------------------------------------------------------------
// tb_game_progress
//
// Purpose:
//   Self-checking bench for game_progress. A behavioural model of the game
//   rules predicts every registered output. A single compare process checks
//   the model against the DUT shortly after every clock edge. A directed
//   sequence pins the model to hand-computed values. A randomized phase then
//   exercises the remaining behaviour. The GODMODE_EN macro selects the
//   god-mode expectations.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_game_progress;

    localparam int MAXH = 3;
    localparam int CD   = 60;

    localparam int M_IDLE    = 0;
    localparam int M_PLAY    = 1;
    localparam int M_CLEARED = 2;
    localparam int M_DEAD    = 3;

    logic        Clk        = 1'b0;
    logic        Reset_n    = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  level      = 3'd0;
    logic        enemy_kill = 1'b0;
    logic        player_hit = 1'b0;
    logic [2:0]  cont;
    logic        health;
    logic [2:0]  hp;
    logic [4:0]  kill_count;
    logic [15:0] score;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    // Model state: the game as the rules describe it.
    int m_mode  = M_IDLE;
    int m_prev  = 0;
    int m_cont  = 0;
    int m_hp    = MAXH;
    int m_kills = 0;
    int m_score = 0;
    int m_cd    = 0;

    game_progress dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .level      (level),
        .enemy_kill (enemy_kill),
        .player_hit (player_hit),
        .cont       (cont),
        .health     (health),
        .hp         (hp),
        .kill_count (kill_count),
        .score      (score)
    );

    always #5 Clk = ~Clk;

    function automatic int kills_needed(input int l);
        case (l)
            1:       return 8;
            2:       return 12;
            3:       return 16;
            default: return 0;
        endcase
    endfunction

    // One clock of game rules, applied to the inputs being presented.
    task automatic model_step();
        int  tgt;
        int  new_hp;
        bit  changed;
        bit  playable;
        bit  kill_ok;
        bit  hit_ok;
        if (!Reset_n) begin
            m_mode  = M_IDLE;
            m_prev  = 0;
            m_cont  = 0;
            m_hp    = MAXH;
            m_kills = 0;
            m_score = 0;
            m_cd    = 0;
            return;
        end
        tgt      = kills_needed(int'(level));
        changed  = (int'(level) != m_prev);
        playable = (level >= 3'd1) && (level <= 3'd3);
        kill_ok  = enemy_kill && (m_mode == M_PLAY) && !changed && playable;
`ifdef GODMODE_EN
        hit_ok   = 1'b0;
`else
        hit_ok   = player_hit && (m_mode == M_PLAY || m_mode == M_CLEARED) &&
                   (m_cd == 0) && (m_hp > 0);
`endif
        if (kill_ok) begin
            m_kills = (m_kills + 1 > tgt) ? tgt : m_kills + 1;
            m_score = m_score + 10 * int'(level);
            if (m_score > 65535) m_score = 65535;
        end
        if (changed) begin
            m_kills = 0;
            m_cont  = 0;
        end
        new_hp = hit_ok ? m_hp - 1 : m_hp;
        if (hit_ok) m_cd = CD;
        else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
        m_hp = new_hp;

        if (m_mode == M_IDLE) begin
            if (playable) m_mode = M_PLAY;
            else if (level == 3'd0) begin
                m_hp = MAXH; m_score = 0; m_kills = 0;
            end
        end else if (m_mode == M_PLAY) begin
            if (m_hp == 0) begin
                m_mode = M_DEAD; m_cont = 0;
            end else if (!playable) begin
                m_mode = M_IDLE;
            end else if (kill_ok && m_kills == tgt) begin
                m_mode = M_CLEARED;
                m_cont = 1 << (int'(level) - 1);
            end
        end else if (m_mode == M_CLEARED) begin
            if (m_hp == 0) begin
                m_mode = M_DEAD; m_cont = 0;
            end else if (changed) begin
                m_mode = playable ? M_PLAY : M_IDLE;
            end
        end else begin
            if (level == 3'd0) begin
                m_mode = M_IDLE; m_hp = MAXH; m_score = 0; m_kills = 0;
            end
        end
        m_prev = int'(level);
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and advance the model.
    // Return once the rising edge and the compare process have both passed.
    task automatic apply_stimulus(input logic rn, input logic [2:0] lv,
                                  input logic k, input logic h, input logic ft);
        @(negedge Clk);
        Reset_n    = rn;
        level      = lv;
        enemy_kill = k;
        player_hit = h;
        frame_tick = ft;
        model_step();
        check_en   = 1'b1;
        @(posedge Clk);
        #2;
    endtask

    // Every cycle, compare all registered outputs against the model.
    always @(posedge Clk) begin
        #1;
        if (check_en) begin
            check_output("cont",       int'(cont),       m_cont);
            check_output("health",     int'(health),     (m_hp != 0) ? 1 : 0);
            check_output("hp",         int'(hp),         m_hp);
            check_output("kill_count", int'(kill_count), m_kills);
            check_output("score",      int'(score),      m_score);
        end
    end

    initial begin
        int lv;

        // Reset.
        apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("lit_reset_cont",   int'(cont),   0);
        check_output("lit_reset_health", int'(health), 1);
        check_output("lit_reset_hp",     int'(hp),     3);
        check_output("lit_reset_score",  int'(score),  0);
        check_output("lit_reset_kills",  int'(kill_count), 0);

        // Level 1 cleared by 8 kills.
        apply_stimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        check_output("lit_l1_cont_before", int'(cont), 0);
        apply_stimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        check_output("lit_l1_cont",  int'(cont),  1);
        check_output("lit_l1_score", int'(score), 80);
        apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        check_output("lit_l2_cont_clear",  int'(cont),       0);
        check_output("lit_l2_kills_clear", int'(kill_count), 0);

`ifndef GODMODE_EN
        // Hit cooldown on level 2.
        apply_stimulus(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        check_output("lit_hit_ignored_hp", int'(hp), 2);
        for (int i = 0; i < 60; i++) apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        check_output("lit_second_hit_hp", int'(hp), 1);

        // A fatal hit coinciding with the level-clearing kill.
        for (int i = 0; i < 11; i++) apply_stimulus(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 49; i++) apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        check_output("lit_dead_hp",     int'(hp),     0);
        check_output("lit_dead_health", int'(health), 0);
        check_output("lit_dead_cont",   int'(cont),   0);
        check_output("lit_dead_score",  int'(score),  320);
        apply_stimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("lit_restart_hp",     int'(hp),     3);
        check_output("lit_restart_health", int'(health), 1);
        check_output("lit_restart_score",  int'(score),  0);
`else
        // In god mode, spaced hits never cost health.
        for (int n = 0; n < 10; n++) begin
            apply_stimulus(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
            check_output("lit_god_hp",     int'(hp),     3);
            check_output("lit_god_health", int'(health), 1);
            for (int i = 0; i < 65; i++) apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        end
        apply_stimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("lit_god_restart_score", int'(score), 0);
`endif

        // Three levels in a row, with the level-3 kill count saturating.
        apply_stimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  apply_stimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        check_output("lit_l3_kills", int'(kill_count), 16);
        check_output("lit_l3_cont",  int'(cont),       4);
        check_output("lit_l3_score", int'(score),      800);

        // Randomized play.
        lv = 0;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 39) == 0)
                lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                                 : int'($urandom_range(0, 3));
            apply_stimulus(logic'($urandom_range(0, 499) != 0), 3'(lv),
                           logic'($urandom_range(0, 2) == 0),
                           logic'($urandom_range(0, 14) == 0),
                           logic'($urandom_range(0, 1)));
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
